// File: rtl/lif_cfg_pkg.sv
// Shared constants and FSM encoding for the LIF neuron parameter loader.
package lif_cfg_pkg;

  localparam int BYTE_W     = 8;
  localparam int SHIFT_W    = 4;
  localparam int FRAME_BITS = 40;
  localparam int CNT_W      = 6;

  localparam logic [BYTE_W-1:0] HDR        = 8'hA5;
  localparam logic [BYTE_W-1:0] DEF_THRESH = 8'd100;
  localparam logic [BYTE_W-1:0] DEF_LEAK   = 8'h25;
  localparam logic [BYTE_W-1:0] DEF_REFR   = 8'd3;

  // Bit-count values seen while the last bit of each field is being shifted in.
  localparam logic [CNT_W-1:0] HDR_LAST = 6'd7;
  localparam logic [CNT_W-1:0] PAY_LAST = 6'd31;
  localparam logic [CNT_W-1:0] CHK_LAST = 6'd39;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_PAY,
    S_CHK,
    S_CHECK,
    S_PEND,
    S_COMMIT,
    S_ERR
  } cfg_state_t;

endpackage

// File: rtl/lif_cfg_shifter.sv
// 40-bit MSB-first frame shift register with a bit counter; clear wins over shift.
module lif_cfg_shifter
  import lif_cfg_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              shift_en,
  input  logic              clear,
  input  logic              bit_in,
  output logic [BYTE_W-1:0] hdr,
  output logic [BYTE_W-1:0] thr,
  output logic [BYTE_W-1:0] leak,
  output logic [BYTE_W-1:0] refr,
  output logic [BYTE_W-1:0] chk,
  output logic [CNT_W-1:0]  bit_count
);

  logic [FRAME_BITS-1:0] sh_reg;
  logic [CNT_W-1:0]      cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_reg  <= '0;
      cnt_reg <= '0;
    end else if (clear) begin
      sh_reg  <= '0;
      cnt_reg <= '0;
    end else if (shift_en) begin
      sh_reg  <= {sh_reg[FRAME_BITS-2:0], bit_in};
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign hdr       = sh_reg[39:32];
  assign thr       = sh_reg[31:24];
  assign leak      = sh_reg[23:16];
  assign refr      = sh_reg[15:8];
  assign chk       = sh_reg[7:0];
  assign bit_count = cnt_reg;

endmodule

// File: rtl/lif_param_loader.sv
// Framed serial parameter loader: validates header/checksum into shadow registers
// and commits atomically to the active neuron parameters while the neuron is idle.
module lif_param_loader
  import lif_cfg_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_mode,
  input  logic               serial_data,
  input  logic               neuron_idle,
  output logic [BYTE_W-1:0]  threshold,
  output logic [SHIFT_W-1:0] leak_fast_shift,
  output logic [SHIFT_W-1:0] leak_slow_shift,
  output logic [BYTE_W-1:0]  refr_cycles,
  output logic               params_update,
  output logic               params_ready,
  output logic               cfg_error
);

  cfg_state_t state_reg, state_next;
  logic load_prev_reg;
  logic cfg_error_reg, committed_once_reg, params_update_reg;
  logic [BYTE_W-1:0] thr_reg, leak_reg, refr_reg;

  logic shift_en, clear, commit, set_err, clr_err;
  logic [BYTE_W-1:0] sh_hdr, sh_thr, sh_leak, sh_refr, sh_chk;
  logic [CNT_W-1:0]  bit_count;

  lif_cfg_shifter u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .shift_en  (shift_en),
    .clear     (clear),
    .bit_in    (serial_data),
    .hdr       (sh_hdr),
    .thr       (sh_thr),
    .leak      (sh_leak),
    .refr      (sh_refr),
    .chk       (sh_chk),
    .bit_count (bit_count)
  );

  always_comb begin
    state_next = state_reg;
    shift_en   = 1'b0;
    clear      = 1'b0;
    commit     = 1'b0;
    set_err    = 1'b0;
    clr_err    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (load_mode && !load_prev_reg) begin
          shift_en   = 1'b1;
          clr_err    = 1'b1;
          state_next = S_HDR;
        end
      end
      S_HDR, S_PAY, S_CHK: begin
        if (!load_mode) begin
          set_err    = 1'b1;
          clear      = 1'b1;
          state_next = S_IDLE;
        end else begin
          shift_en = 1'b1;
          // Header is judged on the edge carrying bit 7, using the incoming bit.
          if (state_reg == S_HDR && bit_count == HDR_LAST) begin
            if ({sh_chk[6:0], serial_data} == HDR) begin
              state_next = S_PAY;
            end else begin
              set_err    = 1'b1;
              state_next = S_ERR;
            end
          end else if (state_reg == S_PAY && bit_count == PAY_LAST) begin
            state_next = S_CHK;
          end else if (state_reg == S_CHK && bit_count == CHK_LAST) begin
            state_next = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if ((sh_thr ^ sh_leak ^ sh_refr) == sh_chk && sh_hdr == HDR) begin
          state_next = S_PEND;
        end else begin
          set_err    = 1'b1;
          state_next = S_ERR;
        end
      end
      S_PEND: begin
        if (neuron_idle) state_next = S_COMMIT;
      end
      S_COMMIT: begin
        commit     = 1'b1;
        clear      = 1'b1;
        state_next = S_IDLE;
      end
      S_ERR: begin
        set_err    = 1'b1;
        clear      = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg          <= S_IDLE;
      load_prev_reg      <= 1'b0;
      cfg_error_reg      <= 1'b0;
      committed_once_reg <= 1'b0;
      params_update_reg  <= 1'b0;
      thr_reg            <= DEF_THRESH;
      leak_reg           <= DEF_LEAK;
      refr_reg           <= DEF_REFR;
    end else begin
      state_reg         <= state_next;
      load_prev_reg     <= load_mode;
      params_update_reg <= commit;
      if (set_err)      cfg_error_reg <= 1'b1;
      else if (clr_err) cfg_error_reg <= 1'b0;
      if (commit) begin
        committed_once_reg <= 1'b1;
        thr_reg            <= sh_thr;
        leak_reg           <= sh_leak;
        refr_reg           <= sh_refr;
      end
    end
  end

  assign threshold       = thr_reg;
  assign leak_fast_shift = leak_reg[7:4];
  assign leak_slow_shift = leak_reg[3:0];
  assign refr_cycles     = refr_reg;
  assign params_update   = params_update_reg;
  assign params_ready    = committed_once_reg && (state_reg == S_IDLE);
  assign cfg_error       = cfg_error_reg;

endmodule

// File: tb/tb_lif_param_loader.sv
// Directed scoreboard bench for lif_param_loader: expected commits are queued at
// send time and checked whenever params_update pulses.
module tb_lif_param_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load_mode = 1'b0;
  logic       serial_data = 1'b0;
  logic       neuron_idle = 1'b1;
  logic [7:0] threshold;
  logic [3:0] leak_fast_shift;
  logic [3:0] leak_slow_shift;
  logic [7:0] refr_cycles;
  logic       params_update;
  logic       params_ready;
  logic       cfg_error;

  lif_param_loader dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .load_mode       (load_mode),
    .serial_data     (serial_data),
    .neuron_idle     (neuron_idle),
    .threshold       (threshold),
    .leak_fast_shift (leak_fast_shift),
    .leak_slow_shift (leak_slow_shift),
    .refr_cycles     (refr_cycles),
    .params_update   (params_update),
    .params_ready    (params_ready),
    .cfg_error       (cfg_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] thr;
    logic [7:0] leak;
    logic [7:0] refr;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   updates = 0;
  logic upd_prev = 1'b0;
  logic rdy_mid;

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: every update pulse must match the oldest queued frame.
  always @(negedge clk) begin
    if (rst_n && params_update === 1'b1) begin
      exp_t e;
      updates++;
      checks++;
      assert (!upd_prev) else begin
        failures++;
        $error("FAIL update_width observed=2+ cycles expected=1 cycle");
      end
      checks++;
      assert (sb_q.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_update observed=pulse expected=none");
      end
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check8("sb_thr", threshold, e.thr);
        check8("sb_fast", {4'h0, leak_fast_shift}, {4'h0, e.leak[7:4]});
        check8("sb_slow", {4'h0, leak_slow_shift}, {4'h0, e.leak[3:0]});
        check8("sb_refr", refr_cycles, e.refr);
      end
      $display("update #%0d thr=%0h fast=%0d slow=%0d refr=%0d", updates,
               threshold, leak_fast_shift, leak_slow_shift, refr_cycles);
    end
    upd_prev = params_update;
  end

  // Returns on the negedge after the edge sampling the last driven bit, load_mode low.
  task automatic send_frame(input logic [39:0] f, input int nbits, input int extra,
                            output logic rdy);
    rdy = 1'bx;
    @(negedge clk) load_mode = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      load_mode   = 1'b1;
      serial_data = f[39-i];
      if (i == 20) rdy = params_ready;
    end
    for (int i = 0; i < extra; i++) begin
      @(negedge clk) serial_data = 1'($urandom);
    end
    @(negedge clk) load_mode = 1'b0;
    $display("frame %010h bits=%0d extra=%0d sent", f, nbits, extra);
  endtask

  task automatic wait_commit(input string tag, input int exp_updates);
    for (int i = 0; i < 20 && updates < exp_updates; i++) @(negedge clk);
    check_int(tag, updates, exp_updates);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. reset values
    idle_cycles(2);
    check8("rst_thr", threshold, 8'd100);
    check8("rst_fast", {4'h0, leak_fast_shift}, 8'd2);
    check8("rst_slow", {4'h0, leak_slow_shift}, 8'd5);
    check8("rst_refr", refr_cycles, 8'd3);
    check8("rst_ready", {7'h0, params_ready}, 8'd0);
    check8("rst_err", {7'h0, cfg_error}, 8'd0);
    rst_n = 1'b1;
    idle_cycles(2);
    check8("rel_thr", threshold, 8'd100);
    check8("rel_refr", refr_cycles, 8'd3);
    check8("rel_upd", {7'h0, params_update}, 8'd0);

    // 2. valid frame, exact commit latency
    sb_q.push_back('{thr: 8'h50, leak: 8'h36, refr: 8'h04});
    send_frame(40'hA5_50_36_04_62, 40, 0, rdy_mid);
    check8("t2_mid_ready", {7'h0, rdy_mid}, 8'd0);
    @(negedge clk) check8("t2_pend_upd", {7'h0, params_update}, 8'd0);
    @(negedge clk) check8("t2_commit_upd", {7'h0, params_update}, 8'd0);
    check8("t2_commit_thr", threshold, 8'd100);
    @(negedge clk) check8("t2_upd", {7'h0, params_update}, 8'd1);
    check8("t2_thr", threshold, 8'h50);
    check8("t2_ready", {7'h0, params_ready}, 8'd1);
    @(negedge clk) check8("t2_upd_off", {7'h0, params_update}, 8'd0);
    check8("t2_ready_hold", {7'h0, params_ready}, 8'd1);
    check_int("t2_updates", updates, 1);

    // 3. bad checksum
    send_frame(40'hA5_50_36_04_63, 40, 0, rdy_mid);
    check8("t3_mid_ready", {7'h0, rdy_mid}, 8'd0);
    idle_cycles(2);
    check8("t3_err", {7'h0, cfg_error}, 8'd1);
    idle_cycles(6);
    check8("t3_thr", threshold, 8'h50);
    check8("t3_ready", {7'h0, params_ready}, 8'd1);
    check_int("t3_updates", updates, 1);

    // 5. abort after bit 20, then a valid frame clears the error
    send_frame(40'hA5_20_13_07_34, 21, 0, rdy_mid);
    idle_cycles(1);
    check8("t5_abort_err", {7'h0, cfg_error}, 8'd1);
    idle_cycles(5);
    check_int("t5_abort_updates", updates, 1);
    check8("t5_abort_thr", threshold, 8'h50);
    sb_q.push_back('{thr: 8'h20, leak: 8'h13, refr: 8'h07});
    send_frame(40'hA5_20_13_07_34, 40, 0, rdy_mid);
    check8("t5_err_cleared", {7'h0, cfg_error}, 8'd0);
    wait_commit("t5_commit", 2);
    check8("t5_thr", threshold, 8'h20);

    // 4. bad header with load_mode held for all 40 bits
    send_frame(40'hA4_11_22_33_00, 40, 0, rdy_mid);
    check8("t4_err", {7'h0, cfg_error}, 8'd1);
    idle_cycles(10);
    check_int("t4_updates", updates, 2);
    check8("t4_thr", threshold, 8'h20);
    check8("t4_ready", {7'h0, params_ready}, 8'd1);

    // load_mode held 8 bits past bit 39: extra bits ignored
    sb_q.push_back('{thr: 8'h7F, leak: 8'h42, refr: 8'h09});
    send_frame(40'hA5_7F_42_09_34, 40, 8, rdy_mid);
    wait_commit("hold_commit", 3);
    check8("hold_err", {7'h0, cfg_error}, 8'd0);
    idle_cycles(10);
    check_int("hold_no_second", updates, 3);

    // 6. neuron busy for 50 cycles after CHECK
    neuron_idle = 1'b0;
    sb_q.push_back('{thr: 8'h33, leak: 8'h11, refr: 8'h0A});
    send_frame(40'hA5_33_11_0A_28, 40, 0, rdy_mid);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check8("t6_busy", {6'h0, params_update, params_ready}, 8'd0);
    end
    neuron_idle = 1'b1;
    @(negedge clk) check8("t6_commit_cycle", {7'h0, params_update}, 8'd0);
    @(negedge clk) check8("t6_upd", {7'h0, params_update}, 8'd1);
    check8("t6_thr", threshold, 8'h33);

    // reset asserted while in PEND restores defaults
    neuron_idle = 1'b0;
    send_frame(40'hA5_44_22_05_63, 40, 0, rdy_mid);
    idle_cycles(5);
    rst_n = 1'b0;
    #1;
    check8("rp_thr", threshold, 8'd100);
    check8("rp_fast", {4'h0, leak_fast_shift}, 8'd2);
    check8("rp_slow", {4'h0, leak_slow_shift}, 8'd5);
    check8("rp_refr", refr_cycles, 8'd3);
    check8("rp_ready", {7'h0, params_ready}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    neuron_idle = 1'b1;
    idle_cycles(10);
    check_int("rp_updates", updates, 4);
    check8("rp_thr_hold", threshold, 8'd100);
    check_int("sb_empty", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
